// File: rtl/imm_gen_pipe_pkg.sv
// Shared immediate-extension op codes and parameter legality helpers for imm_gen_pipe.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        EXT_NONE = 3'd0,
        EXT_I    = 3'd1,
        EXT_S    = 3'd2,
        EXT_B    = 3'd3,
        EXT_U    = 3'd4,
        EXT_J    = 3'd5,
        EXT_Z    = 3'd6,
        EXT_RSV  = 3'd7
    } ext_op_e;

    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 4;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_stage.sv
// One register slot of the immediate pipeline: valid bit plus payload,
// loaded when the advance chain allows, otherwise holding; flush kills the entry.
module imm_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate extender with valid/ready, flush and side-band tag.
// Optional CSR uimm (EXT_Z) support is enabled by defining IMM_GEN_CSR_ZIMM_EN.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int PW = XLEN + TAG_W + 1;

    generate
        if (!xlen_legal(XLEN)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("imm_gen_pipe: DEPTH must be 1..4");
        end
    endgenerate

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;
    logic            unused_opcode;

    assign unused_opcode = ^in_inst[6:0];

    // Extension happens before stage 0 so each stage only carries the finished immediate.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (ext_op_e'(in_op))
            EXT_NONE: ext_imm = '0;
            EXT_I:    ext_imm = XLEN'($signed(in_inst[31:20]));
            EXT_S:    ext_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            EXT_B:    ext_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                               in_inst[11:8], 1'b0}));
            EXT_U:    ext_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            EXT_J:    ext_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                               in_inst[30:21], 1'b0}));
`ifdef IMM_GEN_CSR_ZIMM_EN
            EXT_Z:    ext_imm = XLEN'(in_inst[19:15]);
`endif
            default: begin
                ext_imm = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    logic [DEPTH-1:0] stage_valid;
    logic [PW-1:0]    stage_data [DEPTH];
    logic [DEPTH-1:0] stage_load;

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        logic nxt;
        stage_load = '0;
        nxt        = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            nxt           = !stage_valid[k] || nxt;
            stage_load[k] = nxt;
        end
    end

    assign in_ready = stage_load[0];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic          src_valid;
            logic [PW-1:0] src_data;

            if (k == 0) begin : g_head
                assign src_valid = in_valid;
                assign src_data  = {ext_err, in_tag, ext_imm};
            end else begin : g_body
                assign src_valid = stage_valid[k-1];
                assign src_data  = stage_data[k-1];
            end

            imm_pipe_stage #(
                .W(PW)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .load     (stage_load[k]),
                .in_valid (src_valid),
                .in_data  (src_data),
                .out_valid(stage_valid[k]),
                .out_data (stage_data[k])
            );
        end
    endgenerate

    assign out_valid = stage_valid[DEPTH-1];
    assign out_imm   = out_valid ? stage_data[DEPTH-1][XLEN-1:0]          : '0;
    assign out_tag   = out_valid ? stage_data[DEPTH-1][XLEN+TAG_W-1:XLEN] : '0;
    assign out_err   = out_valid ? stage_data[DEPTH-1][PW-1]              : 1'b0;

endmodule
